axi_single_beat_master: RTL and testbench

- CPU-side request-to-AXI4 master bridge, instantiated inside CPU_wrapper once per master port.
  - Master0: instruction fetch, read only.
  - Master1: data load/store.
- Converts a simple CPU memory request (req/we/addr/wdata/wstrb) into one single-beat AXI4 read or write transaction.
- Drives the AXI master pins that go to the interconnect and the AXI protocol monitor.
- Stalls the CPU until the response returns, then hands back read data and an error flag.

---
 rtl/axi_single_beat_master.sv | 245 ++++++++++++++++++++++++
 tb/tb_axi_single_beat_master.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_single_beat_master.sv
// axi_single_beat_master
// Bridges a simple CPU memory request (req/we/addr/wdata/wstrb) onto one
// single-beat AXI4 read or write transaction and stalls the CPU until the
// response returns.
// Optional watchdog: define AXI_MASTER_TIMEOUT_EN to enable a per-state cycle
// counter that raises a sticky timeout_err after TIMEOUT_CYCLES cycles.
// Without the macro there is no counter and timeout_err is tied low.

module axi_single_beat_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int MASTER_ID      = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  // CPU side
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0] cpu_wstrb,
  output logic                    cpu_busy,
  output logic                    cpu_done,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    cpu_err,
  // Write address channel
  output logic [ID_WIDTH-1:0]     AWID,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [3:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output logic [1:0]              AWBURST,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  // Write data channel
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  // Write response channel
  input  logic [ID_WIDTH-1:0]     BID,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  // Read address channel
  output logic [ID_WIDTH-1:0]     ARID,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [3:0]              ARLEN,
  output logic [2:0]              ARSIZE,
  output logic [1:0]              ARBURST,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  // Read data channel
  input  logic [ID_WIDTH-1:0]     RID,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  output logic                    RREADY,
  // Watchdog
  output logic                    timeout_err
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_WR,
    ST_B
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    arValid_q;
  logic                    rReady_q;
  logic                    awValid_q;
  logic                    wValid_q;
  logic                    bReady_q;
  logic                    awDone_q;
  logic                    wDone_q;
  logic                    done_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    wrBothDone;

  // A write phase finishes once each channel has handshaken, now or earlier.
  assign wrBothDone = (awDone_q || AWREADY) && (wDone_q || WREADY);

  // Main transaction FSM; all AXI and CPU handshake outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arValid_q <= 1'b0;
      rReady_q  <= 1'b0;
      awValid_q <= 1'b0;
      wValid_q  <= 1'b0;
      bReady_q  <= 1'b0;
      awDone_q  <= 1'b0;
      wDone_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            wstrb_q <= cpu_wstrb;
            if (cpu_we) begin
              state_q   <= ST_WR;
              awValid_q <= 1'b1;
              wValid_q  <= 1'b1;
              awDone_q  <= 1'b0;
              wDone_q   <= 1'b0;
            end else begin
              state_q   <= ST_AR;
              arValid_q <= 1'b1;
            end
          end
        end
        ST_AR: begin
          if (ARREADY) begin
            arValid_q <= 1'b0;
            rReady_q  <= 1'b1;
            state_q   <= ST_R;
          end
        end
        ST_R: begin
          if (RVALID && RLAST) begin
            rReady_q <= 1'b0;
            rdata_q  <= RDATA;
            err_q    <= RRESP[1];
            done_q   <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        ST_WR: begin
          if (awValid_q && AWREADY) begin
            awValid_q <= 1'b0;
            awDone_q  <= 1'b1;
          end
          if (wValid_q && WREADY) begin
            wValid_q <= 1'b0;
            wDone_q  <= 1'b1;
          end
          if (wrBothDone) begin
            bReady_q <= 1'b1;
            awDone_q <= 1'b0;
            wDone_q  <= 1'b0;
            state_q  <= ST_B;
          end
        end
        ST_B: begin
          if (BVALID) begin
            bReady_q <= 1'b0;
            err_q    <= BRESP[1];
            done_q   <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu_busy  = (state_q != ST_IDLE);
  assign cpu_done  = done_q;
  assign cpu_rdata = rdata_q;
  assign cpu_err   = err_q;

  assign AWID    = ID_WIDTH'(MASTER_ID);
  assign AWADDR  = addr_q;
  assign AWLEN   = 4'd0;
  assign AWSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign AWVALID = awValid_q;

  assign WDATA  = wdata_q;
  assign WSTRB  = wstrb_q;
  assign WLAST  = wValid_q;
  assign WVALID = wValid_q;

  assign BREADY = bReady_q;

  assign ARID    = ID_WIDTH'(MASTER_ID);
  assign ARADDR  = addr_q;
  assign ARLEN   = 4'd0;
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign ARVALID = arValid_q;

  assign RREADY = rReady_q;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] timeoutCnt_q;
  logic          timeout_q;
  logic          enterState;

  // Any transition that lands in AR, R, WR or B restarts the per-state count.
  assign enterState = ((state_q == ST_IDLE) && cpu_req) ||
                      ((state_q == ST_AR) && ARREADY) ||
                      ((state_q == ST_WR) && wrBothDone);

  // Saturating per-state cycle counter with a sticky flag; the FSM keeps waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeoutCnt_q <= '0;
      timeout_q    <= 1'b0;
    end else if (enterState) begin
      timeoutCnt_q <= '0;
    end else if ((state_q != ST_IDLE) && (timeoutCnt_q != CW'(TIMEOUT_CYCLES))) begin
      timeoutCnt_q <= timeoutCnt_q + CW'(1);
      if (timeoutCnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_q;

  logic unusedInputs;
  assign unusedInputs = ^{RID, BID, RRESP[0], BRESP[0]};
`else
  localparam logic [31:0] TIMEOUT_VEC = TIMEOUT_CYCLES;

  assign timeout_err = 1'b0;

  logic unusedInputs;
  assign unusedInputs = ^{RID, BID, RRESP[0], BRESP[0], TIMEOUT_VEC};
`endif

endmodule

// File: tb/tb_axi_single_beat_master.sv
// tb_axi_single_beat_master
// Directed bench for axi_single_beat_master: a table of zero-wait transactions
// plus hand-written sequences for out-of-order write handshakes, back-to-back
// requests, mid-transaction reset and the ARREADY stall / watchdog case.

module tb_axi_single_beat_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IW  = 4;
  localparam int SW  = DW / 8;
  localparam int MID = 5;
  localparam int TO  = 8;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [SW-1:0] cpu_wstrb;
  logic          cpu_busy;
  logic          cpu_done;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_err;
  logic [IW-1:0] AWID;
  logic [AW-1:0] AWADDR;
  logic [3:0]    AWLEN;
  logic [2:0]    AWSIZE;
  logic [1:0]    AWBURST;
  logic          AWVALID;
  logic          AWREADY;
  logic [DW-1:0] WDATA;
  logic [SW-1:0] WSTRB;
  logic          WLAST;
  logic          WVALID;
  logic          WREADY;
  logic [IW-1:0] BID;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY;
  logic [IW-1:0] ARID;
  logic [AW-1:0] ARADDR;
  logic [3:0]    ARLEN;
  logic [2:0]    ARSIZE;
  logic [1:0]    ARBURST;
  logic          ARVALID;
  logic          ARREADY;
  logic [IW-1:0] RID;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RLAST;
  logic          RVALID;
  logic          RREADY;
  logic          timeout_err;

  int checks   = 0;
  int failures = 0;

  axi_single_beat_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .MASTER_ID(MID), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY),
    .timeout_err(timeout_err)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever loses its way.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    logic          expErr;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_wstrb = wstrb;
  endtask

  task automatic idleSlave();
    AWREADY = 1'b0; WREADY = 1'b0;
    BID = '0; BRESP = 2'b00; BVALID = 1'b0;
    ARREADY = 1'b0;
    RID = '0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;
  endtask

  // One transaction against a zero-wait slave, starting at a negedge (cycle 0).
  task automatic runVector(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    applyStimulus(v.we, v.addr, v.wdata, v.wstrb);
    @(negedge clk);
    checkOutput({tag, " busy c1"}, cpu_busy, 1'b1);
    if (v.we) begin
      checkOutput({tag, " AWVALID c1"}, AWVALID, 1'b1);
      checkOutput({tag, " WVALID c1"}, WVALID, 1'b1);
      checkOutput({tag, " WLAST c1"}, WLAST, 1'b1);
      checkOutput({tag, " ARVALID c1"}, ARVALID, 1'b0);
      checkOutput({tag, " AWADDR"}, AWADDR, v.addr);
      checkOutput({tag, " WDATA"}, WDATA, v.wdata);
      checkOutput({tag, " WSTRB"}, WSTRB, v.wstrb);
      checkOutput({tag, " AWID"}, AWID, IW'(MID));
      checkOutput({tag, " AWLEN"}, AWLEN, 4'd0);
      checkOutput({tag, " AWSIZE"}, AWSIZE, 3'b010);
      checkOutput({tag, " AWBURST"}, AWBURST, 2'b01);
      AWREADY = 1'b1; WREADY = 1'b1;
    end else begin
      checkOutput({tag, " ARVALID c1"}, ARVALID, 1'b1);
      checkOutput({tag, " AWVALID c1"}, AWVALID, 1'b0);
      checkOutput({tag, " ARADDR"}, ARADDR, v.addr);
      checkOutput({tag, " ARID"}, ARID, IW'(MID));
      checkOutput({tag, " ARLEN"}, ARLEN, 4'd0);
      checkOutput({tag, " ARSIZE"}, ARSIZE, 3'b010);
      checkOutput({tag, " ARBURST"}, ARBURST, 2'b01);
      ARREADY = 1'b1;
    end
    @(negedge clk);
    checkOutput({tag, " done c2"}, cpu_done, 1'b0);
    if (v.we) begin
      checkOutput({tag, " BREADY c2"}, BREADY, 1'b1);
      checkOutput({tag, " AWVALID c2"}, AWVALID, 1'b0);
      checkOutput({tag, " WVALID c2"}, WVALID, 1'b0);
      AWREADY = 1'b0; WREADY = 1'b0;
      BVALID = 1'b1; BRESP = v.resp;
    end else begin
      checkOutput({tag, " RREADY c2"}, RREADY, 1'b1);
      checkOutput({tag, " ARVALID c2"}, ARVALID, 1'b0);
      ARREADY = 1'b0;
      RVALID = 1'b1; RDATA = v.rdata; RRESP = v.resp; RLAST = 1'b1;
    end
    @(negedge clk);
    checkOutput({tag, " done c3"}, cpu_done, 1'b1);
    checkOutput({tag, " err c3"}, cpu_err, v.expErr);
    checkOutput({tag, " busy c3"}, cpu_busy, 1'b0);
    if (v.we) begin
      checkOutput({tag, " BREADY c3"}, BREADY, 1'b0);
    end else begin
      checkOutput({tag, " rdata c3"}, cpu_rdata, v.rdata);
      checkOutput({tag, " RREADY c3"}, RREADY, 1'b0);
    end
    idleSlave();
    cpu_req = 1'b0;
    @(negedge clk);
    checkOutput({tag, " done c4"}, cpu_done, 1'b0);
  endtask

  // Top-level sequence: reset checks, vector table, then corner-case sequences.
  initial begin
    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'hCAFE_0001, 2'b10, 1'b1};
    vecs[2] = '{1'b0, 32'h0000_0024, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b00, 1'b0};
    vecs[3] = '{1'b1, 32'h1000_0008, 32'hAABB_CCDD, 4'hF, 32'h0, 2'b00, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0030, 32'h0, 4'h0, 32'h7654_3210, 2'b01, 1'b0};
    vecs[5] = '{1'b1, 32'h1000_000C, 32'h0000_0000, 4'h0, 32'h0, 2'b11, 1'b1};

    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    idleSlave();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", cpu_busy, 1'b0);
    checkOutput("reset done", cpu_done, 1'b0);
    checkOutput("reset err", cpu_err, 1'b0);
    checkOutput("reset rdata", cpu_rdata, '0);
    checkOutput("reset ARVALID", ARVALID, 1'b0);
    checkOutput("reset AWVALID", AWVALID, 1'b0);
    checkOutput("reset WVALID", WVALID, 1'b0);
    checkOutput("reset RREADY", RREADY, 1'b0);
    checkOutput("reset BREADY", BREADY, 1'b0);
    checkOutput("reset ARADDR", ARADDR, '0);
    checkOutput("reset WDATA", WDATA, '0);
    checkOutput("reset timeout", timeout_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      runVector(vecs[i], i);
    end

    // WREADY arrives two cycles before AWREADY; err was left at 1 by vec5.
    applyStimulus(1'b1, 32'h1000_0004, 32'h1234_5678, 4'b0011);
    @(negedge clk);
    checkOutput("wOrder AWVALID c1", AWVALID, 1'b1);
    checkOutput("wOrder WVALID c1", WVALID, 1'b1);
    checkOutput("wOrder WSTRB", WSTRB, 4'b0011);
    WREADY = 1'b1;
    @(negedge clk);
    checkOutput("wOrder WVALID c2", WVALID, 1'b0);
    checkOutput("wOrder AWVALID c2", AWVALID, 1'b1);
    checkOutput("wOrder BREADY c2", BREADY, 1'b0);
    checkOutput("wOrder AWADDR c2", AWADDR, 32'h1000_0004);
    WREADY = 1'b0;
    @(negedge clk);
    checkOutput("wOrder AWVALID c3", AWVALID, 1'b1);
    checkOutput("wOrder WVALID c3", WVALID, 1'b0);
    checkOutput("wOrder BREADY c3", BREADY, 1'b0);
    AWREADY = 1'b1;
    @(negedge clk);
    checkOutput("wOrder AWVALID c4", AWVALID, 1'b0);
    checkOutput("wOrder BREADY c4", BREADY, 1'b1);
    AWREADY = 1'b0; BVALID = 1'b1; BRESP = 2'b00;
    @(negedge clk);
    checkOutput("wOrder done c5", cpu_done, 1'b1);
    checkOutput("wOrder err c5", cpu_err, 1'b0);
    idleSlave();
    cpu_req = 1'b0;
    @(negedge clk);
    checkOutput("wOrder done c6", cpu_done, 1'b0);

    // Read, then a write presented in the cpu_done cycle.
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    @(negedge clk);
    ARREADY = 1'b1;
    @(negedge clk);
    ARREADY = 1'b0; RVALID = 1'b1; RDATA = 32'h55AA_55AA; RRESP = 2'b00; RLAST = 1'b1;
    @(negedge clk);
    checkOutput("b2b done c3", cpu_done, 1'b1);
    checkOutput("b2b rdata c3", cpu_rdata, 32'h55AA_55AA);
    idleSlave();
    applyStimulus(1'b1, 32'h2000_0000, 32'hFEED_FACE, 4'hF);
    @(negedge clk);
    checkOutput("b2b AWVALID c4", AWVALID, 1'b1);
    checkOutput("b2b WVALID c4", WVALID, 1'b1);
    checkOutput("b2b AWADDR c4", AWADDR, 32'h2000_0000);
    checkOutput("b2b WDATA c4", WDATA, 32'hFEED_FACE);
    checkOutput("b2b done c4", cpu_done, 1'b0);
    AWREADY = 1'b1; WREADY = 1'b1;
    @(negedge clk);
    checkOutput("b2b BREADY c5", BREADY, 1'b1);
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b1; BRESP = 2'b00;
    @(negedge clk);
    checkOutput("b2b done c6", cpu_done, 1'b1);
    idleSlave();
    cpu_req = 1'b0;
    @(negedge clk);
    checkOutput("b2b done c7", cpu_done, 1'b0);
    checkOutput("b2b busy c7", cpu_busy, 1'b0);

    // Reset while waiting in R with RVALID low.
    applyStimulus(1'b0, 32'h0000_0080, 32'h0, 4'h0);
    @(negedge clk);
    ARREADY = 1'b1;
    @(negedge clk);
    checkOutput("midRst RREADY c2", RREADY, 1'b1);
    ARREADY = 1'b0;
    rst = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    checkOutput("midRst RREADY c3", RREADY, 1'b0);
    checkOutput("midRst busy c3", cpu_busy, 1'b0);
    checkOutput("midRst done c3", cpu_done, 1'b0);
    checkOutput("midRst ARVALID c3", ARVALID, 1'b0);
    checkOutput("midRst rdata c3", cpu_rdata, '0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRst done c4", cpu_done, 1'b0);
    runVector('{1'b0, 32'h0000_0084, 32'h0, 4'h0, 32'h1357_9BDF, 2'b00, 1'b0}, 6);

    // ARREADY held low: ARVALID must persist; watchdog fires only when enabled.
    applyStimulus(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    repeat (8) @(negedge clk);
    checkOutput("stall ARVALID c8", ARVALID, 1'b1);
    checkOutput("stall timeout c8", timeout_err, 1'b0);
    @(negedge clk);
    checkOutput("stall ARVALID c9", ARVALID, 1'b1);
    checkOutput("stall ARADDR c9", ARADDR, 32'h0000_0100);
    checkOutput("stall timeout c9", timeout_err, TO_EN);
    ARREADY = 1'b1;
    @(negedge clk);
    checkOutput("stall RREADY c10", RREADY, 1'b1);
    ARREADY = 1'b0; RVALID = 1'b1; RDATA = 32'hA5A5_0F0F; RRESP = 2'b00; RLAST = 1'b1;
    @(negedge clk);
    checkOutput("stall done c11", cpu_done, 1'b1);
    checkOutput("stall rdata c11", cpu_rdata, 32'hA5A5_0F0F);
    idleSlave();
    cpu_req = 1'b0;
    @(negedge clk);
    checkOutput("stall timeout sticky", timeout_err, TO_EN);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
